// File: rtl/store_narrow_pkg.sv
// Shared encodings for the store-narrowing path.
// Size codes match the load extenders; state codes name the output/skid occupancy.
package store_narrow_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_OUT   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store lane formatter.
// Replicates the operand across lanes and builds byte enables.
module store_lane_fmt
    import store_narrow_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_lanes,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata_lanes = wdata;
        be          = 4'b0000;
        misaligned  = 1'b0;
        unique case (1'b1)
            (size == SZ_BYTE): begin
                wdata_lanes = {4{wdata[7:0]}};
                be          = 4'b0001 << addr;
            end
            (size == SZ_HALF): begin
                wdata_lanes = {2{wdata[15:0]}};
                be          = 4'b0011 << {addr[1], 1'b0};
                misaligned  = addr[0];
            end
            (size == SZ_WORD): begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            (size == SZ_ILL): begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// Store narrowing stage: lane formatting, registered output with skid,
// and trapping of misaligned or illegal-size stores.
module store_narrow
    import store_narrow_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [1:0]        in_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_count
);

    logic [31:0]       fmt_wdata;
    logic [3:0]        fmt_be;
    logic              fmt_mis;
    logic [ADDR_W-1:0] in_waddr;

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] sk_addr;
    logic [31:0]       sk_wdata;
    logic [3:0]        sk_be;

    logic acc;
    logic legal;
    logic trap;
    logic ld_in;
    logic ld_sk;
    logic sk_wr;

    store_lane_fmt u_fmt (
        .size        (in_size),
        .addr        (in_addr[1:0]),
        .wdata       (in_wdata),
        .wdata_lanes (fmt_wdata),
        .be          (fmt_be),
        .misaligned  (fmt_mis)
    );

    assign in_waddr  = {in_addr[ADDR_W-1:2], 2'b00};
    assign acc       = in_valid & in_ready;
    assign legal     = acc & ~fmt_mis;
    assign trap      = acc & fmt_mis;
    assign mem_valid = (state != ST_EMPTY);

    always_comb begin
        state_d = state;
        ld_in   = 1'b0;
        ld_sk   = 1'b0;
        sk_wr   = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (legal) begin
                    ld_in   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (mem_ready) begin
                    if (legal) ld_in = 1'b1;
                    else       state_d = ST_EMPTY;
                end else if (legal) begin
                    sk_wr   = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (mem_ready) begin
                    ld_sk   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            sk_addr   <= '0;
            sk_wdata  <= '0;
            sk_be     <= '0;
        end else begin
            state    <= state_d;
            in_ready <= (state_d != ST_FULL);
            if (ld_in) begin
                mem_addr  <= in_waddr;
                mem_wdata <= fmt_wdata;
                mem_be    <= fmt_be;
            end else if (ld_sk) begin
                mem_addr  <= sk_addr;
                mem_wdata <= sk_wdata;
                mem_be    <= sk_be;
            end
            if (sk_wr) begin
                sk_addr  <= in_waddr;
                sk_wdata <= fmt_wdata;
                sk_be    <= fmt_be;
            end
        end
    end

    // Trapped stores only touch error state; they never enter the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            err_pulse <= trap;
            if (trap) err_addr <= in_addr;
            if (trap && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow.
// Checks lanes, enables, traps, saturation, back-pressure and reset.
module tb_store_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err_pulse;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    store_narrow #(.ADDR_W(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_size   (in_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        in_valid = v;
        in_addr  = a;
        in_wdata = d;
        in_size  = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #12;
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_err_count", {24'b0, err_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // byte store
        drive(1'b1, 32'h103, 32'hDEADBEEF, 2'b00);
        tick();
        in_valid = 1'b0;
        chk("b_valid", {31'b0, mem_valid}, 32'h1);
        chk("b_addr", mem_addr, 32'h100);
        chk("b_wdata", mem_wdata, 32'hEFEFEFEF);
        chk("b_be", {28'b0, mem_be}, 32'h8);
        tick();
        chk("b_drain", {31'b0, mem_valid}, 32'h0);

        // half then word back-to-back
        drive(1'b1, 32'h22, 32'h1234ABCD, 2'b01);
        tick();
        chk("h_addr", mem_addr, 32'h20);
        chk("h_wdata", mem_wdata, 32'hABCDABCD);
        chk("h_be", {28'b0, mem_be}, 32'hC);
        drive(1'b1, 32'h40, 32'hCAFEF00D, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("w_addr", mem_addr, 32'h40);
        chk("w_wdata", mem_wdata, 32'hCAFEF00D);
        chk("w_be", {28'b0, mem_be}, 32'hF);
        tick();
        chk("w_drain", {31'b0, mem_valid}, 32'h0);

        // traps
        drive(1'b1, 32'h21, 32'h11111111, 2'b01);
        tick();
        chk("t1_pulse", {31'b0, err_pulse}, 32'h1);
        chk("t1_valid", {31'b0, mem_valid}, 32'h0);
        chk("t1_count", {24'b0, err_count}, 32'h1);
        drive(1'b1, 32'h50, 32'h22222222, 2'b11);
        tick();
        in_valid = 1'b0;
        chk("t2_pulse", {31'b0, err_pulse}, 32'h1);
        chk("t2_valid", {31'b0, mem_valid}, 32'h0);
        chk("t2_addr", err_addr, 32'h50);
        chk("t2_count", {24'b0, err_count}, 32'h2);
        tick();
        chk("t_pulse_off", {31'b0, err_pulse}, 32'h0);

        // saturation: 298 more misaligned words -> 300 total
        drive(1'b1, 32'h3, 32'h0, 2'b10);
        repeat (252) @(posedge clk);
        #1;
        chk("sat_254", {24'b0, err_count}, 32'd254);
        repeat (46) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sat_255", {24'b0, err_count}, 32'd255);
        chk("sat_valid", {31'b0, mem_valid}, 32'h0);

        // back-pressure A,B,C
        mem_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hAAAA0001, 2'b10);
        tick();
        chk("bp_a_out", mem_wdata, 32'hAAAA0001);
        chk("bp_rdy1", {31'b0, in_ready}, 32'h1);
        drive(1'b1, 32'h204, 32'hBBBB0002, 2'b10);
        tick();
        chk("bp_a_hold", mem_wdata, 32'hAAAA0001);
        chk("bp_rdy0", {31'b0, in_ready}, 32'h0);
        drive(1'b1, 32'h208, 32'hCCCC0003, 2'b10);
        tick();
        chk("bp_a_hold2", mem_addr, 32'h200);
        chk("bp_c_wait", {31'b0, in_ready}, 32'h0);
        mem_ready = 1'b1;
        tick();
        chk("bp_b_addr", mem_addr, 32'h204);
        chk("bp_b_data", mem_wdata, 32'hBBBB0002);
        chk("bp_rdy_back", {31'b0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_addr", mem_addr, 32'h208);
        chk("bp_c_data", mem_wdata, 32'hCCCC0003);
        tick();
        chk("bp_drain", {31'b0, mem_valid}, 32'h0);

        // stream of 10 at full rate
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 2'b10);
            tick();
            chk("st_valid", {31'b0, mem_valid}, 32'h1);
            chk("st_data", mem_wdata, 32'h1000 + 32'(i));
            chk("st_ready", {31'b0, in_ready}, 32'h1);
        end

        // trap while last stream store drains
        drive(1'b1, 32'h301, 32'h0, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("td_valid", {31'b0, mem_valid}, 32'h0);
        chk("td_pulse", {31'b0, err_pulse}, 32'h1);
        chk("td_addr", err_addr, 32'h301);

        // reset while FULL
        mem_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h44440000, 2'b10);
        tick();
        drive(1'b1, 32'h404, 32'h55550000, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("rf_full", {31'b0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rf_valid", {31'b0, mem_valid}, 32'h0);
        chk("rf_wdata", mem_wdata, 32'h0);
        chk("rf_be", {28'b0, mem_be}, 32'h0);
        chk("rf_count", {24'b0, err_count}, 32'h0);
        chk("rf_eaddr", err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rf_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rf_lost", {31'b0, mem_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
